instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 5 +
 rtl/instr_fetch_unit_next_pc_sel.sv | 19 +
 rtl/instr_fetch_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared state encoding and PC increment for the fetch unit
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// next_pc_sel: redirect priority jr > jump > branch > sequential, with word alignment
module next_pc_sel (
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  // misaligned targets are truncated to a word boundary and flagged
  always_comb begin
    next_pc = jr ? {jr_target[31:2], 2'b00} : jump ? {pc_plus4[31:28], jump_index, 2'b00} :
              branch_taken ? {branch_target[31:2], 2'b00} : pc_plus4;
    misaligned = jr ? |jr_target[1:0] : !jump && branch_taken && |branch_target[1:0];
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IDLE/FETCH/HOLD fetch FSM feeding one held instruction to the datapath
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  state_t state, state_nx;
  logic [31:0] fetch_pc, next_pc;
  logic misaligned, fetch_go, ack_go;

  assign imem_req    = state == FETCH;
  assign instr_valid = state == HOLD;
  assign imem_addr   = fetch_pc;
  assign pc_plus4    = pc + PC_INC;
  assign fetch_go    = imem_req && imem_ready;
  assign ack_go      = instr_valid && instr_ack;

  next_pc_sel u_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  // next state: leave IDLE at once, wait for memory in FETCH, wait for consumer in HOLD
  always_comb begin
    state_nx = state == IDLE ? FETCH : state == FETCH ? (imem_ready ? HOLD : FETCH) :
               (instr_ack ? FETCH : HOLD);
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end

  // capture fetched word on ready, advance PC and count on ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc     <= RESET_PC;
      instr        <= '0;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      misalign_err <= ack_go && misaligned;
      if (fetch_go) begin
        instr <= imem_rdata;
        pc    <= fetch_pc;
      end
      if (ack_go) begin
        fetch_pc    <= next_pc;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end
endmodule
